// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module : regfile_pkg
// Brief  : Shared widths and FSM state encodings for the register-file write port.
// Rev    : 1.0  initial release
// ============================================================================
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_SEL_W  = 5;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

endpackage
`default_nettype wire

// File: rtl/regfile_req_fifo.sv
`default_nettype none
// ============================================================================
// Module : regfile_req_fifo
// Brief  : Synchronous request FIFO; push when full and pop when empty are ignored.
// Rev    : 1.0  initial release
// ============================================================================
module regfile_req_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 37,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_push;
    logic             w_pop;

    assign full     = (r_level == LVL_W'(DEPTH));
    assign empty    = (r_level == '0);
    assign level    = r_level;
    assign pop_data = r_mem[r_rd_ptr];

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Storage carries no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_write_port.sv
`default_nettype none
// ============================================================================
// Module : regfile_write_port
// Brief  : Buffered write driver for the register file with a zero-sweep mode.
//          Optional REGFILE_R0_ZERO_EN: requests to register 0 are accepted but dropped.
// Rev    : 1.0  initial release
// ============================================================================
module regfile_write_port
    import regfile_pkg::*;
#(
    parameter  int DATA_W     = DEF_DATA_W,
    parameter  int SEL_W      = DEF_SEL_W,
    parameter  int DEPTH      = 4,
    parameter  int CLR_ON_RST = 1,
    localparam int LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [SEL_W-1:0]  req_sel,
    input  logic [DATA_W-1:0] req_data,
    input  logic              clr_req,
    output logic              busy,
    output logic [LVL_W-1:0]  level,
    output logic              w_en,
    output logic [SEL_W-1:0]  w_sel,
    output logic [DATA_W-1:0] d
);

    localparam logic [1:0] RST_STATE = (CLR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
    localparam int         ENTRY_W   = SEL_W + DATA_W;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [SEL_W-1:0]   r_clr_k;
    logic               w_accept;
    logic               w_store;
    logic               w_pop;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [ENTRY_W-1:0] w_pop_data;

    assign busy      = (r_state != ST_RUN);
    assign req_ready = (r_state == ST_RUN) && !w_fifo_full;
    assign w_accept  = req_valid && req_ready;

`ifdef REGFILE_R0_ZERO_EN
    assign w_store = w_accept && (req_sel != '0);
`else
    assign w_store = w_accept;
`endif

    // The sweep never pops, so anything queued stays put until RUN resumes.
    assign w_pop = (r_state != ST_CLEAR) && !w_fifo_empty;

    regfile_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_store),
        .push_data ({req_sel, req_data}),
        .pop       (w_pop),
        .pop_data  (w_pop_data),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .level     (level)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN: begin
                // A request stored on the same edge must still drain ahead of the sweep.
                if (clr_req) begin
                    w_next_state = (w_fifo_empty && !w_store) ? ST_CLEAR : ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (level <= LVL_W'(1)) begin
                    w_next_state = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (r_clr_k == {SEL_W{1'b1}}) begin
                    w_next_state = ST_RUN;
                end
            end
            default: w_next_state = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RST_STATE;
            r_clr_k <= '0;
            w_en    <= 1'b0;
            w_sel   <= '0;
            d       <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_CLEAR) begin
                // Counter wraps back to zero after the last register, ready for the next sweep.
                w_en    <= 1'b1;
                w_sel   <= r_clr_k;
                d       <= '0;
                r_clr_k <= r_clr_k + SEL_W'(1);
            end else if (w_pop) begin
                w_en  <= 1'b1;
                w_sel <= w_pop_data[DATA_W +: SEL_W];
                d     <= w_pop_data[DATA_W-1:0];
            end else begin
                w_en <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
